// File: rtl/goboard_7seg_decode.sv
// Recovers hex digits from seven active-low segment lines. Each line is synchronised, the pattern is debounced, then decoded.
// Latency is STABLE_CYCLES+3 clocks from pin change to output. Results use a valid/ready handshake, and an unaccepted digit is overwritten and flagged.
module goboard_7seg_decode #(
    parameter int STABLE_CYCLES = 12000,
    parameter int CNT_W         = $clog2(STABLE_CYCLES)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ledA_i,
    input  logic       ledB_i,
    input  logic       ledC_i,
    input  logic       ledD_i,
    input  logic       ledE_i,
    input  logic       ledF_i,
    input  logic       ledG_i,
    output logic [3:0] value_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       blank_o,
    output logic       error_o,
    output logic       overrun_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic {SETTLING, STABLE} state_t;

    logic [6:0]       pins, sync1, sync2, seg;
    logic [6:0]       cand, last;
    logic [CNT_W-1:0] cnt;
    state_t           state, state_nxt;
    logic             settle, act;
    logic             dec_legal;
    logic [3:0]       dec_digit;

    assign pins = {ledA_i, ledB_i, ledC_i, ledD_i, ledE_i, ledF_i, ledG_i};
    assign seg  = ~sync2;

    // Reset to all-high so an idle display reads as blank, matching cand/last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= pins;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= STABLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        settle    = 1'b0;
        if (seg != cand) begin
            state_nxt = SETTLING;
        end else if (state == SETTLING && cnt == CNT_MAX) begin
            state_nxt = STABLE;
            settle    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand <= '0;
            cnt  <= '0;
        end else if (seg != cand) begin
            cand <= seg;
            cnt  <= '0;
        end else if (state == SETTLING && cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        dec_legal = 1'b1;
        dec_digit = 4'h0;
        case (cand)
            7'b1111110: dec_digit = 4'h0;
            7'b0110000: dec_digit = 4'h1;
            7'b1101101: dec_digit = 4'h2;
            7'b1111001: dec_digit = 4'h3;
            7'b0110011: dec_digit = 4'h4;
            7'b1011011: dec_digit = 4'h5;
            7'b1011111: dec_digit = 4'h6;
            7'b1110000: dec_digit = 4'h7;
            7'b1111111: dec_digit = 4'h8;
            7'b1111011: dec_digit = 4'h9;
            7'b1110111: dec_digit = 4'hA;
            7'b0011111: dec_digit = 4'hB;
            7'b1001110: dec_digit = 4'hC;
            7'b0111101: dec_digit = 4'hD;
            7'b1001111: dec_digit = 4'hE;
            7'b1000111: dec_digit = 4'hF;
            default:    dec_legal = 1'b0;
        endcase
    end

    // A glitch that settles back onto the previously reported pattern is ignored.
    assign act = settle && (cand != last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last      <= '0;
            value_o   <= '0;
            valid_o   <= 1'b0;
            blank_o   <= 1'b1;
            error_o   <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            error_o   <= 1'b0;
            overrun_o <= 1'b0;
            if (act) begin
                last <= cand;
            end
            if (act && dec_legal) begin
                value_o   <= dec_digit;
                valid_o   <= 1'b1;
                blank_o   <= 1'b0;
                overrun_o <= valid_o && !ready_i;
            end else begin
                if (valid_o && ready_i) begin
                    valid_o <= 1'b0;
                end
                if (act && cand == 7'b0000000) begin
                    blank_o <= 1'b1;
                end else if (act) begin
                    error_o <= 1'b1;
                    blank_o <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_goboard_7seg_decode.sv
// Directed bench for goboard_7seg_decode with a short debounce window.
module tb_goboard_7seg_decode;

    localparam int SC = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ledA_i = 1'b1, ledB_i = 1'b1, ledC_i = 1'b1, ledD_i = 1'b1;
    logic       ledE_i = 1'b1, ledF_i = 1'b1, ledG_i = 1'b1;
    logic       ready_i = 1'b0;
    logic [3:0] value_o;
    logic       valid_o, blank_o, error_o, overrun_o;

    int checks = 0;
    int errors = 0;
    int ovr_cnt = 0;
    int err_cnt = 0;
    logic [3:0] got_q[$];

    logic [6:0] seg_tab [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    goboard_7seg_decode #(.STABLE_CYCLES(SC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ledA_i    (ledA_i),
        .ledB_i    (ledB_i),
        .ledC_i    (ledC_i),
        .ledD_i    (ledD_i),
        .ledE_i    (ledE_i),
        .ledF_i    (ledF_i),
        .ledG_i    (ledG_i),
        .value_o   (value_o),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .blank_o   (blank_o),
        .error_o   (error_o),
        .overrun_o (overrun_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (overrun_o) ovr_cnt++;
        if (error_o) err_cnt++;
        if (valid_o && ready_i) got_q.push_back(value_o);
    end

    // s is segments a..g, 1 = lit
    task automatic set_seg(input logic [6:0] s);
        {ledA_i, ledB_i, ledC_i, ledD_i, ledE_i, ledF_i, ledG_i} = ~s;
    endtask

    task automatic settle_wait();
        repeat (SC + 6) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({value_o, valid_o, blank_o, error_o, overrun_o} !== 8'b0000_0100) begin
            errors++;
            $display("FAIL reset_values: got v=%h vld=%b blk=%b err=%b ovr=%b, want 0 0 1 0 0",
                     value_o, valid_o, blank_o, error_o, overrun_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        settle_wait();
        checks++;
        if (blank_o !== 1'b1 || valid_o !== 1'b0 || err_cnt != 0) begin
            errors++;
            $display("FAIL idle_after_reset: got blk=%b vld=%b errs=%0d, want 1 0 0", blank_o, valid_o, err_cnt);
        end
    endtask

    task automatic test_latency();
        ready_i = 1'b0;
        @(negedge clk);
        set_seg(seg_tab[5]);
        repeat (SC + 2) @(negedge clk);
        checks++;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: got valid=%b after edge %0d, want 0", valid_o, SC + 2);
        end
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b1 || value_o !== 4'h5 || blank_o !== 1'b0) begin
            errors++;
            $display("FAIL latency_edge: got vld=%b val=%h blk=%b, want 1 5 0", valid_o, value_o, blank_o);
        end
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        checks++;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("FAIL accept_clears: got valid=%b, want 0", valid_o);
        end
    endtask

    task automatic test_glitch();
        int ovr0;
        set_seg(seg_tab[3]);
        settle_wait();
        checks++;
        if (valid_o !== 1'b1 || value_o !== 4'h3) begin
            errors++;
            $display("FAIL glitch_first: got vld=%b val=%h, want 1 3", valid_o, value_o);
        end
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        ovr0 = ovr_cnt;
        set_seg(seg_tab[8]);
        repeat (2) @(negedge clk);
        set_seg(seg_tab[3]);
        repeat (SC + 8) @(negedge clk);
        checks++;
        if (valid_o !== 1'b0 || ovr_cnt != ovr0 || err_cnt != 0) begin
            errors++;
            $display("FAIL glitch_no_event: got vld=%b ovr=%0d errs=%0d, want 0 %0d 0",
                     valid_o, ovr_cnt, ovr0, err_cnt);
        end
    endtask

    task automatic test_all_digits();
        ready_i = 1'b1;
        got_q.delete();
        for (int d = 0; d < 16; d++) begin
            set_seg(seg_tab[d]);
            settle_wait();
        end
        checks++;
        if (got_q.size() != 16) begin
            errors++;
            $display("FAIL digits_count: got %0d deliveries, want 16", got_q.size());
        end
        for (int d = 0; d < 16 && d < got_q.size(); d++) begin
            checks++;
            if (got_q[d] !== 4'(d)) begin
                errors++;
                $display("FAIL digit_%0d: got %h, want %h", d, got_q[d], 4'(d));
            end
        end
        set_seg(7'b0000000);
        settle_wait();
        checks++;
        if (blank_o !== 1'b1) begin
            errors++;
            $display("FAIL blank_set: got blank=%b, want 1", blank_o);
        end
        set_seg(seg_tab[15]);
        settle_wait();
        checks++;
        if (blank_o !== 1'b0 || got_q.size() != 17 || got_q[got_q.size()-1] !== 4'hF) begin
            errors++;
            $display("FAIL redeliver_after_blank: got blk=%b n=%0d, want 0 17 with F last", blank_o, got_q.size());
        end
        ready_i = 1'b0;
    endtask

    task automatic test_error();
        int e0;
        set_seg(seg_tab[7]);
        settle_wait();
        e0 = err_cnt;
        set_seg(7'b1010101);
        settle_wait();
        checks++;
        if (err_cnt != e0 + 1) begin
            errors++;
            $display("FAIL error_pulse: got %0d pulses, want 1", err_cnt - e0);
        end
        checks++;
        if (valid_o !== 1'b1 || value_o !== 4'h7 || blank_o !== 1'b0) begin
            errors++;
            $display("FAIL error_keeps: got vld=%b val=%h blk=%b, want 1 7 0", valid_o, value_o, blank_o);
        end
    endtask

    task automatic test_overrun();
        int o0;
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        o0 = ovr_cnt;
        set_seg(seg_tab[1]);
        settle_wait();
        checks++;
        if (valid_o !== 1'b1 || value_o !== 4'h1 || ovr_cnt != o0) begin
            errors++;
            $display("FAIL ovr_first: got vld=%b val=%h ovr=%0d, want 1 1 %0d", valid_o, value_o, ovr_cnt, o0);
        end
        set_seg(seg_tab[2]);
        settle_wait();
        checks++;
        if (valid_o !== 1'b1 || value_o !== 4'h2 || ovr_cnt != o0 + 1) begin
            errors++;
            $display("FAIL ovr_overwrite: got vld=%b val=%h ovr=%0d, want 1 2 %0d", valid_o, value_o, ovr_cnt, o0 + 1);
        end
    endtask

    task automatic test_back_to_back();
        int o0;
        o0 = ovr_cnt;
        @(negedge clk);
        set_seg(seg_tab[9]);
        repeat (SC + 2) @(negedge clk);
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        checks++;
        if (valid_o !== 1'b1 || value_o !== 4'h9 || ovr_cnt != o0) begin
            errors++;
            $display("FAIL b2b_load: got vld=%b val=%h ovr=%0d, want 1 9 %0d", valid_o, value_o, ovr_cnt, o0);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        set_seg(seg_tab[4]);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({value_o, valid_o, blank_o, error_o, overrun_o} !== 8'b0000_0100) begin
            errors++;
            $display("FAIL reset_async: got v=%h vld=%b blk=%b err=%b ovr=%b, want 0 0 1 0 0",
                     value_o, valid_o, blank_o, error_o, overrun_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (SC + 2) @(negedge clk);
        checks++;
        if (valid_o !== 1'b0 || blank_o !== 1'b1) begin
            errors++;
            $display("FAIL refilter_early: got vld=%b blk=%b, want 0 1", valid_o, blank_o);
        end
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b1 || value_o !== 4'h4) begin
            errors++;
            $display("FAIL refilter_accept: got vld=%b val=%h, want 1 4", valid_o, value_o);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_all_digits();
        test_error();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
